// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Memory-stage load/store unit sitting between the M stage of the pipeline and
// a variable-latency word bus. Each aligned access becomes exactly one word
// transaction with byte enables; the pipeline is stalled until the bus acks.
// Misaligned accesses fault in the same cycle and never reach the bus.
//
// Ports
//   clk          in   1   clock, rising edge
//   reset        in   1   asynchronous, active-low
//   MemReadM     in   1   load in M stage
//   MemWriteM    in   1   store in M stage (wins over MemReadM)
//   funct3M      in   3   access size / signedness
//   ALUResultM   in  32   byte address
//   WriteDataM   in  32   store data, right-aligned
//   ReadDataM    out 32   extended load data (valid in DONE)
//   StallM       out  1   freeze F/D/E/M, bubble W
//   FaultM       out  1   one-cycle pulse: misaligned access or bus timeout
//   bus_req      out  1   registered request, high for exactly the WAIT cycles
//   bus_we       out  1   write strobe
//   bus_addr     out 32   word address
//   bus_wdata    out 32   lane-replicated store data
//   bus_be       out  4   byte enables
//   bus_ack      in   1   completion, sampled only in WAIT
//   bus_rdata    in  32   read word, valid with bus_ack
//
// Build option
//   LSU_BUS_TIMEOUT_EN : when defined, a WAIT lasting TIMEOUT_CYCLES cycles
//                        without bus_ack is forced to DONE with FaultM.
//                        When undefined, WAIT holds until bus_ack.
//
// state | meaning
// IDLE  | no transaction; aligned access launches, misaligned access faults
// WAIT  | bus_req high, waiting for bus_ack (or timeout)
// DONE  | result on ReadDataM, pipeline released at end of cycle
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        FaultM,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // Unlisted funct3 codes fall through to word size.
  function automatic logic [1:0] size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: size_of = SZ_B;
      3'b001, 3'b101: size_of = SZ_H;
      default:        size_of = SZ_W;
    endcase
  endfunction

  state_t      r_state;
  state_t      w_state_next;

  logic        r_bus_req;
  logic        r_bus_we;
  logic [31:0] r_bus_addr;
  logic [31:0] r_bus_wdata;
  logic [3:0]  r_bus_be;
  logic [2:0]  r_f3;
  logic [1:0]  r_off;
  logic [31:0] r_rdata;

  logic        w_access;
  logic [1:0]  w_size;
  logic        w_misaligned;
  logic        w_start;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_shifted;
  logic [31:0] w_load_ext;
  logic        w_timeout;
  logic        w_timed_out;

  assign w_access     = MemReadM | MemWriteM;
  assign w_size       = size_of(funct3M);
  assign w_misaligned = w_access &
                        (((w_size == SZ_H) & ALUResultM[0]) |
                         ((w_size == SZ_W) & (ALUResultM[1:0] != 2'b00)));
  assign w_start      = (r_state == S_IDLE) & w_access & ~w_misaligned;

  // Loads always read the whole word; only stores narrow the enables.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = WriteDataM;
    if (MemWriteM) begin
      case (w_size)
        SZ_B: begin
          w_be    = 4'b0001 << ALUResultM[1:0];
          w_wdata = {4{WriteDataM[7:0]}};
        end
        SZ_H: begin
          w_be    = ALUResultM[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{WriteDataM[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = WriteDataM;
        end
      endcase
    end
  end

`ifdef LSU_BUS_TIMEOUT_EN
  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  // The counter reads 0 in the first WAIT cycle, so the last permitted
  // WAIT cycle is the one where it reads TIMEOUT_CYCLES-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_timed_out;

  assign w_timeout   = (r_state == S_WAIT) & ~bus_ack & (r_cnt == CNT_LAST);
  assign w_timed_out = r_timed_out;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt       <= '0;
      r_timed_out <= 1'b0;
    end else begin
      if (w_start) begin
        r_cnt <= '0;
      end else if ((r_state == S_WAIT) && !bus_ack) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      // Re-evaluated every WAIT cycle; holds through DONE for the fault pulse.
      if (r_state == S_WAIT) begin
        r_timed_out <= w_timeout;
      end
    end
  end
`else
  logic w_unused_timeout;

  assign w_timeout        = 1'b0;
  assign w_timed_out      = 1'b0;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_state_next = S_WAIT;
      S_WAIT: if (bus_ack || w_timeout) w_state_next = S_DONE;
      S_DONE: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_shifted = r_rdata >> {r_off, 3'b000};
    case (size_of(r_f3))
      SZ_B:    w_load_ext = r_f3[2] ? {24'd0, w_shifted[7:0]}
                                    : {{24{w_shifted[7]}}, w_shifted[7:0]};
      SZ_H:    w_load_ext = r_f3[2] ? {16'd0, w_shifted[15:0]}
                                    : {{16{w_shifted[15]}}, w_shifted[15:0]};
      default: w_load_ext = w_shifted;
    endcase
  end

  always_comb begin
    StallM    = w_start | (r_state == S_WAIT);
    FaultM    = ((r_state == S_IDLE) & w_misaligned) |
                ((r_state == S_DONE) & w_timed_out);
    ReadDataM = 32'd0;
    if ((r_state == S_DONE) && !r_bus_we && !w_timed_out) begin
      ReadDataM = w_load_ext;
    end
  end

  // ---------------------------------------------------------------------------
  // Bus-side registers: launched in IDLE, held stable through WAIT
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= 32'd0;
      r_bus_wdata <= 32'd0;
      r_bus_be    <= 4'd0;
      r_f3        <= 3'd0;
      r_off       <= 2'd0;
      r_rdata     <= 32'd0;
    end else begin
      r_bus_req <= (w_state_next == S_WAIT);
      if (w_start) begin
        r_bus_we    <= MemWriteM;
        r_bus_addr  <= {ALUResultM[31:2], 2'b00};
        r_bus_wdata <= w_wdata;
        r_bus_be    <= w_be;
        r_f3        <= funct3M;
        r_off       <= ALUResultM[1:0];
      end
      if ((r_state == S_WAIT) && bus_ack && !r_bus_we) begin
        r_rdata <= bus_rdata;
      end
    end
  end

  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;
  assign bus_be    = r_bus_be;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        MemReadM;
  logic        MemWriteM;
  logic [2:0]  funct3M;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallM;
  logic        FaultM;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int n_checks;
  int n_pass;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .funct3M    (funct3M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .FaultM     (FaultM),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_be     (bus_be),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
  endtask

  // One full aligned access: IDLE (stalled), waits+1 WAIT cycles, DONE.
  task automatic do_access(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rd, input int waits,
                           input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                           input logic [31:0] exp_rd);
    int stalls;
    int req_hi;
    stalls = 0;
    req_hi = 0;
    @(negedge clk);
    MemReadM   = ~we;
    MemWriteM  = we;
    funct3M    = f3;
    ALUResultM = addr;
    WriteDataM = wd;
    #1;
    check({tag, "/idle_req"}, 32'(bus_req), 32'd0);
    check({tag, "/idle_fault"}, 32'(FaultM), 32'd0);
    if (StallM) stalls++;
    for (int i = 0; i <= waits; i++) begin
      @(negedge clk);
      if (StallM) stalls++;
      if (bus_req) req_hi++;
      if (i == 0) begin
        check({tag, "/addr"}, bus_addr, {addr[31:2], 2'b00});
        check({tag, "/we"}, 32'(bus_we), 32'(we));
        check({tag, "/be"}, 32'(bus_be), 32'(exp_be));
        if (we) check({tag, "/wdata"}, bus_wdata, exp_wdata);
      end
      if (i == waits) begin
        bus_ack   = 1'b1;
        bus_rdata = rd;
      end
    end
    @(negedge clk);
    bus_ack   = 1'b0;
    bus_rdata = 32'h5A5A_5A5A;
    if (StallM) stalls++;
    check({tag, "/rdata"}, ReadDataM, exp_rd);
    check({tag, "/done_req"}, 32'(bus_req), 32'd0);
    check({tag, "/done_fault"}, 32'(FaultM), 32'd0);
    check({tag, "/stalls"}, 32'(stalls), 32'(waits + 2));
    check({tag, "/req_cycles"}, 32'(req_hi), 32'(waits + 1));
    MemReadM  = 1'b0;
    MemWriteM = 1'b0;
    @(negedge clk);
    check({tag, "/after_rdata"}, ReadDataM, 32'd0);
    check({tag, "/after_stall"}, 32'(StallM), 32'd0);
  endtask

  task automatic misaligned(input string tag, input logic we, input logic [2:0] f3,
                            input logic [31:0] addr);
    @(negedge clk);
    MemReadM   = ~we;
    MemWriteM  = we;
    funct3M    = f3;
    ALUResultM = addr;
    #1;
    check({tag, "/fault"}, 32'(FaultM), 32'd1);
    check({tag, "/stall"}, 32'(StallM), 32'd0);
    check({tag, "/rdata"}, ReadDataM, 32'd0);
    check({tag, "/req"}, 32'(bus_req), 32'd0);
    @(negedge clk);
    check({tag, "/req_next"}, 32'(bus_req), 32'd0);
    MemReadM  = 1'b0;
    MemWriteM = 1'b0;
    #1;
    check({tag, "/fault_clear"}, 32'(FaultM), 32'd0);
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    reset      = 1'b0;
    MemReadM   = 1'b0;
    MemWriteM  = 1'b0;
    funct3M    = 3'b000;
    ALUResultM = 32'd0;
    WriteDataM = 32'd0;
    bus_ack    = 1'b0;
    bus_rdata  = 32'd0;

    repeat (2) @(negedge clk);
    check("rst/req", 32'(bus_req), 32'd0);
    check("rst/we", 32'(bus_we), 32'd0);
    check("rst/be", 32'(bus_be), 32'd0);
    check("rst/addr", bus_addr, 32'd0);
    check("rst/wdata", bus_wdata, 32'd0);
    check("rst/rdata", ReadDataM, 32'd0);
    check("rst/stall", 32'(StallM), 32'd0);
    check("rst/fault", 32'(FaultM), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("idle/stall", 32'(StallM), 32'd0);

    // Loads
    do_access("lw100", 1'b0, 3'b010, 32'h100, 32'd0, 32'hDEAD_BEEF, 0, 4'b1111, 32'd0, 32'hDEAD_BEEF);
    do_access("lb103", 1'b0, 3'b000, 32'h103, 32'd0, 32'h80FF_1234, 0, 4'b1111, 32'd0, 32'hFFFF_FF80);
    do_access("lbu103", 1'b0, 3'b100, 32'h103, 32'd0, 32'h80FF_1234, 0, 4'b1111, 32'd0, 32'h0000_0080);
    do_access("lhu102", 1'b0, 3'b101, 32'h102, 32'd0, 32'h80FF_1234, 0, 4'b1111, 32'd0, 32'h0000_80FF);
    do_access("lh102", 1'b0, 3'b001, 32'h102, 32'd0, 32'h80FF_1234, 0, 4'b1111, 32'd0, 32'hFFFF_80FF);
    do_access("lb101", 1'b0, 3'b000, 32'h101, 32'd0, 32'h80FF_1234, 1, 4'b1111, 32'd0, 32'h0000_0012);
    do_access("lw_wait2", 1'b0, 3'b010, 32'h204, 32'd0, 32'h1357_9BDF, 2, 4'b1111, 32'd0, 32'h1357_9BDF);

    // Stores
    do_access("sb101", 1'b1, 3'b000, 32'h101, 32'h0000_00AB, 32'hFFFF_FFFF, 0, 4'b0010, 32'hABAB_ABAB, 32'd0);
    do_access("sh102", 1'b1, 3'b001, 32'h102, 32'h0000_1234, 32'hFFFF_FFFF, 0, 4'b1100, 32'h1234_1234, 32'd0);
    do_access("sh100", 1'b1, 3'b001, 32'h100, 32'hFFFF_5678, 32'hFFFF_FFFF, 1, 4'b0011, 32'h5678_5678, 32'd0);
    do_access("sw200", 1'b1, 3'b010, 32'h200, 32'hCAFE_F00D, 32'hFFFF_FFFF, 0, 4'b1111, 32'hCAFE_F00D, 32'd0);

    // Misaligned
    misaligned("lw102", 1'b0, 3'b010, 32'h102);
    misaligned("lhu101", 1'b0, 3'b101, 32'h101);
    misaligned("sw201", 1'b1, 3'b010, 32'h201);

    // Reset in the second WAIT cycle, ack arrives after release
    @(negedge clk);
    MemReadM   = 1'b1;
    funct3M    = 3'b010;
    ALUResultM = 32'h300;
    @(negedge clk);
    check("rstmid/req_wait1", 32'(bus_req), 32'd1);
    @(negedge clk);
    reset    = 1'b0;
    MemReadM = 1'b0;
    #1;
    check("rstmid/req", 32'(bus_req), 32'd0);
    check("rstmid/stall", 32'(StallM), 32'd0);
    check("rstmid/rdata", ReadDataM, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    bus_ack   = 1'b1;
    bus_rdata = 32'h7777_7777;
    #1;
    check("rstmid/ack_req", 32'(bus_req), 32'd0);
    @(negedge clk);
    bus_ack = 1'b0;
    check("rstmid/post_req", 32'(bus_req), 32'd0);
    check("rstmid/post_rdata", ReadDataM, 32'd0);
    check("rstmid/post_stall", 32'(StallM), 32'd0);
    check("rstmid/post_fault", 32'(FaultM), 32'd0);
    do_access("lw_after_rst", 1'b0, 3'b010, 32'h308, 32'd0, 32'h2468_ACE0, 0, 4'b1111, 32'd0, 32'h2468_ACE0);

`ifdef LSU_BUS_TIMEOUT_EN
    begin
      int  req_hi;
      bit  done;
      req_hi = 0;
      done   = 1'b0;
      @(negedge clk);
      MemReadM   = 1'b1;
      funct3M    = 3'b010;
      ALUResultM = 32'h400;
      for (int i = 0; i < 12 && !done; i++) begin
        @(negedge clk);
        if (bus_req) begin
          req_hi++;
        end else if (!StallM) begin
          check("tmo/fault", 32'(FaultM), 32'd1);
          check("tmo/rdata", ReadDataM, 32'd0);
          done     = 1'b1;
          MemReadM = 1'b0;
        end
      end
      check("tmo/completed", 32'(done), 32'd1);
      check("tmo/req_cycles", 32'(req_hi), 32'd4);
      MemReadM = 1'b0;
      @(negedge clk);
      check("tmo/fault_clear", 32'(FaultM), 32'd0);
      check("tmo/idle_stall", 32'(StallM), 32'd0);
    end
`endif

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit between the pipelined datapath's M stage and a variable-latency data bus. It turns an M-stage access (address, store data, funct3) into one aligned word transaction with byte enables, and stalls the pipeline until the bus acknowledges. It returns sign- or zero-extended load data on ReadDataM for the W pipeline register. It traps misaligned accesses without issuing a bus cycle.

## Interface
- TIMEOUT_CYCLES, 255: WAIT cycles without bus_ack before forced completion with fault. Used only with LSU_BUS_TIMEOUT_EN.
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- MemReadM  in  1  load in M stage
- MemWriteM  in  1  store in M stage; wins if both are high (treated as store)
- funct3M  in  3  000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu; other codes are handled as word
- ALUResultM  in  32  byte address
- WriteDataM  in  32  store data, right-aligned
- ReadDataM  out  32  extended load data
- StallM  out  1  freeze F/D/E/M and bubble W while high
- FaultM  out  1  one-cycle pulse: misaligned access, or bus timeout
- bus_req  out  1  registered request
- bus_we  out  1  write strobe, valid with bus_req
- bus_addr  out  32  word address {ALUResultM[31:2],2'b00}
- bus_wdata  out  32  lane-replicated store data
- bus_be  out  4  byte enables
- bus_ack  in  1  completion; sampled only in WAIT
- bus_rdata  in  32  read word, valid with bus_ack

## Operation
- Access: MemReadM|MemWriteM. Misaligned: lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]!=0.
- FSM states:
  - IDLE: aligned access → WAIT. Latch bus_addr, bus_we, bus_be, bus_wdata, funct3 and addr[1:0]. Misaligned access → stay IDLE; FaultM=1 and no bus cycle.
  - WAIT: bus_req=1. bus_ack → DONE, capture bus_rdata when it is a load. With macro, counter reaching TIMEOUT_CYCLES → DONE with error.
  - DONE: drive ReadDataM → IDLE. FaultM=1 when the access ended by timeout.
- StallM (combinational) = (IDLE & access & aligned) | WAIT. It is 0 in DONE, so the pipeline advances at the end of the DONE cycle.
- Store lanes:
  - sb: be=1<<addr[1:0], wdata={4{WriteDataM[7:0]}}
  - sh: be=addr[1]?1100:0011, wdata={2{WriteDataM[15:0]}}
  - sw: be=1111, wdata=WriteDataM
- Loads always use be=1111. The captured word is shifted right by addr[1:0]*8, then sign-extended from bit 7 (lb) or bit 15 (lh), or zero-extended (lbu, lhu).
- ReadDataM = 0 in all of these cases: IDLE with misaligned access, timeout completion, stores, no access.
- bus_ack outside WAIT is ignored. bus_req never re-asserts in DONE.

## Timing
- Reset values: state=IDLE, bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, timeout counter=0, captured data=0. ReadDataM=0, FaultM=0, and StallM=0 for as long as no access is presented.
- Reset asserted mid-transaction: bus_req drops asynchronously and the transaction is abandoned. A later bus_ack is ignored.
- Latency with zero-wait bus (ack in first WAIT cycle): IDLE, WAIT, DONE = 3 cycles in M, 2 of them stalled. Each extra wait cycle adds one stall.
- Misaligned access: 0 stall cycles; FaultM in the same cycle as the access.
- bus_req is high for exactly the WAIT cycles. Address, control and data stay stable until the ack is sampled.
- Back-to-back accesses: DONE is always followed by IDLE, so there is never more than one outstanding request.

## Configuration
- LSU_BUS_TIMEOUT_EN defined:
  - Counter of $clog2(TIMEOUT_CYCLES+1) bits, cleared on entry to WAIT.
  - On reaching TIMEOUT_CYCLES without ack: → DONE, ReadDataM=0, FaultM pulses in the DONE cycle.
- Undefined: no counter; WAIT holds until bus_ack, indefinitely. FaultM comes only from misalignment. TIMEOUT_CYCLES is unused.

## Test plan
- lw 0x100, ack in first WAIT cycle with rdata=0xDEADBEEF → bus_addr=0x100, be=1111, StallM high 2 cycles, ReadDataM=0xDEADBEEF in DONE.
- lb 0x103, rdata=0x80FF1234 → ReadDataM=0xFFFFFF80; lbu → 0x00000080; lhu 0x102 → 0x000080FF.
- sb 0x101, WriteDataM=0x000000AB → bus_we=1, be=0010, wdata=0xABABABAB; sh 0x102 data 0x1234 → be=1100, wdata=0x12341234.
- lw 0x102 → FaultM=1 same cycle, StallM=0, bus_req stays 0, ReadDataM=0.
- With LSU_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack → bus_req high 4 cycles, then DONE with FaultM=1, ReadDataM=0, back to IDLE.
- reset driven low in 2nd WAIT cycle, ack arrives after release → bus_req low immediately, state IDLE, ReadDataM=0, StallM=0.
